// File: rtl/ad7124_pkg.sv
// Shared definitions for the AD7124 scan-frame writer: frame geometry, FSM states and
// the per-channel record packing used by the driver.
package ad7124_pkg;

  localparam logic [12:0] BANK_STRIDE = 13'h800;
  localparam int          HDR_WORDS   = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_COLLECT,
    ST_HDR_SEC,
    ST_HDR_NSEC,
    ST_CLOSE
  } state_t;

  function automatic int num_ch(input int boards, input int tc_per_board);
    return boards * (tc_per_board + 1);
  endfunction

  function automatic logic [31:0] pack_record(input logic [7:0] status, input logic [23:0] data);
    return {status, data};
  endfunction

endpackage

// File: rtl/ad7124_frame_writer.sv
// Packs per-channel AD7124 results plus an RTC timestamp into a ping-pong BRAM frame and
// pulses irq when a frame is complete.
module ad7124_frame_writer
  import ad7124_pkg::*;
#(
  parameter int NUM_OF_BOARD        = 6,
  parameter int NUM_OF_TC_PER_BOARD = 8
) (
  input  logic        aclk,
  input  logic        areset,
  input  logic        enable,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic [5:0]  s_ch,
  input  logic [23:0] s_data,
  input  logic [7:0]  s_status,
  input  logic        s_last,
  input  logic [31:0] rtc_sec,
  input  logic [31:0] rtc_nsec,
  output logic        bram_clk,
  output logic        bram_rst,
  output logic        bram_en,
  output logic [3:0]  bram_we,
  output logic [12:0] bram_addr,
  output logic [31:0] bram_wrdata,
  output logic        irq,
  output logic        done_bank,
  output logic [31:0] frame_cnt,
  output logic        err_ch,
  input  logic        err_clr
);

  localparam int         NUM_CH   = num_ch(NUM_OF_BOARD, NUM_OF_TC_PER_BOARD);
  localparam logic [6:0] NUM_CH_W = 7'(NUM_CH);

  state_t      state, state_nxt;
  logic        wr_bank;
  logic        frame_open;
  logic [31:0] ts_sec, ts_nsec;
  logic        collecting, accept, take, in_range;
  logic [12:0] base, slot_addr;

  assign bram_clk   = aclk;
  assign bram_rst   = areset;
  assign collecting = (state == ST_IDLE) || (state == ST_COLLECT);
  assign accept     = s_valid & s_ready;
  assign take       = accept & enable & collecting;
  assign in_range   = {1'b0, s_ch} < NUM_CH_W;
  assign base       = wr_bank ? BANK_STRIDE : 13'h000;
  assign slot_addr  = base + ((13'(s_ch) + 13'(HDR_WORDS)) << 2);

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE, ST_COLLECT: begin
        if (!enable)     state_nxt = ST_IDLE;
        else if (accept) state_nxt = s_last ? ST_HDR_SEC : ST_COLLECT;
      end
      ST_HDR_SEC:  state_nxt = ST_HDR_NSEC;
      ST_HDR_NSEC: state_nxt = ST_CLOSE;
      ST_CLOSE:    state_nxt = ST_IDLE;
      default:     state_nxt = ST_IDLE;
    endcase
  end

  // Timestamp is captured by the first accepted sample of a frame and held until the header.
  always_ff @(posedge aclk) begin
    if (take && !frame_open) begin
      ts_sec  <= rtc_sec;
      ts_nsec <= rtc_nsec;
    end
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      state       <= ST_IDLE;
      s_ready     <= 1'b0;
      bram_en     <= 1'b0;
      bram_we     <= 4'h0;
      bram_addr   <= 13'h000;
      bram_wrdata <= 32'h0;
      irq         <= 1'b0;
      done_bank   <= 1'b0;
      frame_cnt   <= 32'h0;
      err_ch      <= 1'b0;
      wr_bank     <= 1'b0;
      frame_open  <= 1'b0;
    end else begin
      state   <= state_nxt;
      s_ready <= (state_nxt == ST_IDLE) || (state_nxt == ST_COLLECT);
      bram_en <= 1'b0;
      bram_we <= 4'h0;
      irq     <= 1'b0;

      if (err_clr)               err_ch <= 1'b0;
      else if (take && !in_range) err_ch <= 1'b1;

      case (state)
        ST_IDLE, ST_COLLECT: begin
          if (!enable) begin
            frame_open <= 1'b0;
          end else if (accept) begin
            frame_open <= 1'b1;
            if (in_range) begin
              bram_en     <= 1'b1;
              bram_we     <= 4'hF;
              bram_addr   <= slot_addr;
              bram_wrdata <= pack_record(s_status, s_data);
            end
          end
        end
        ST_HDR_SEC: begin
          bram_en     <= 1'b1;
          bram_we     <= 4'hF;
          bram_addr   <= base;
          bram_wrdata <= ts_sec;
        end
        ST_HDR_NSEC: begin
          bram_en     <= 1'b1;
          bram_we     <= 4'hF;
          bram_addr   <= base + 13'd4;
          bram_wrdata <= ts_nsec;
        end
        ST_CLOSE: begin
          done_bank  <= wr_bank;
          wr_bank    <= ~wr_bank;
          frame_cnt  <= frame_cnt + 32'd1;
          irq        <= 1'b1;
          frame_open <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ad7124_frame_writer.sv
// Bench for ad7124_frame_writer: BRAM write scoreboard fed by an independent frame model,
// an err_ch vector table, and directed multi-cycle sequences.
module tb_ad7124_frame_writer;

  logic        aclk = 1'b0;
  logic        areset, enable, s_valid, s_last, err_clr;
  logic        s_ready;
  logic [5:0]  s_ch;
  logic [23:0] s_data;
  logic [7:0]  s_status;
  logic [31:0] rtc_sec, rtc_nsec;
  logic        bram_clk, bram_rst, bram_en, irq, done_bank, err_ch;
  logic [3:0]  bram_we;
  logic [12:0] bram_addr;
  logic [31:0] bram_wrdata, frame_cnt;

  ad7124_frame_writer dut (
    .aclk(aclk), .areset(areset), .enable(enable),
    .s_valid(s_valid), .s_ready(s_ready), .s_ch(s_ch), .s_data(s_data),
    .s_status(s_status), .s_last(s_last), .rtc_sec(rtc_sec), .rtc_nsec(rtc_nsec),
    .bram_clk(bram_clk), .bram_rst(bram_rst), .bram_en(bram_en), .bram_we(bram_we),
    .bram_addr(bram_addr), .bram_wrdata(bram_wrdata), .irq(irq), .done_bank(done_bank),
    .frame_cnt(frame_cnt), .err_ch(err_ch), .err_clr(err_clr)
  );

  always #5 aclk = ~aclk;

  localparam int NCH = 54;

  typedef struct packed {
    logic [12:0] addr;
    logic [31:0] data;
  } wr_t;

  typedef struct {
    logic       valid;
    logic [5:0] ch;
    logic       clr;
    logic       last;
    logic       exp_err;
  } err_vec_t;

  wr_t         exp_q[$];
  logic [31:0] mem [0:2047];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          irq_cnt  = 0;
  logic        m_open   = 1'b0;
  logic        m_bank   = 1'b0;
  logic [31:0] m_sec, m_nsec;
  logic        track    = 1'b0;
  int          run      = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Reference model and write scoreboard, evaluated mid-cycle.
  always @(negedge aclk) begin
    wr_t  e;
    logic [12:0] b;
    if (bram_en) begin
      if (exp_q.size() == 0) begin
        chk("spurious_write_en", 32'(bram_en), 32'h0);
      end else begin
        e = exp_q.pop_front();
        chk("wr_addr", 32'(bram_addr), 32'(e.addr));
        chk("wr_data", bram_wrdata, e.data);
        chk("wr_we", 32'(bram_we), 32'hF);
      end
      mem[bram_addr[12:2]] = bram_wrdata;
    end else begin
      chk("we_idle", 32'(bram_we), 32'h0);
    end
    if (irq) irq_cnt++;
    if (track) begin
      if (!s_ready) run++;
      else begin
        chk("ready_low_cycles", 32'(run), 32'd3);
        track = 1'b0;
      end
    end
    if (areset) begin
      exp_q.delete();
      m_open = 1'b0;
      m_bank = 1'b0;
      track  = 1'b0;
    end else if (s_ready) begin
      if (!enable) begin
        m_open = 1'b0;
      end else if (s_valid) begin
        b = m_bank ? 13'h800 : 13'h000;
        if (!m_open) begin
          m_sec  = rtc_sec;
          m_nsec = rtc_nsec;
          m_open = 1'b1;
        end
        if (int'(s_ch) < NCH) exp_q.push_back('{b + 13'(4 * (2 + int'(s_ch))), {s_status, s_data}});
        if (s_last) begin
          exp_q.push_back('{b, m_sec});
          exp_q.push_back('{b + 13'd4, m_nsec});
          m_open = 1'b0;
          m_bank = ~m_bank;
          track  = 1'b1;
          run    = 0;
        end
      end
    end
  end

  task automatic send(input logic [5:0] ch, input logic [23:0] d, input logic [7:0] st, input logic last);
    int n = 0;
    s_valid = 1'b1; s_ch = ch; s_data = d; s_status = st; s_last = last;
    @(negedge aclk);
    while (!s_ready && n < 20) begin
      @(negedge aclk);
      n++;
    end
    if (!s_ready) chk("send_ready_timeout", 32'(s_ready), 32'h1);
    @(posedge aclk); #1;
  endtask

  task automatic send_frame(input logic [31:0] sec, input logic [31:0] nsec,
                            input logic [23:0] doff, input logic keep_valid);
    rtc_sec = sec; rtc_nsec = nsec;
    for (int c = 0; c < NCH; c++) begin
      send(6'(c), doff + 24'(c), 8'h80, c == NCH - 1);
      if (c == 0) begin
        rtc_sec  = sec + 32'd1000;
        rtc_nsec = nsec + 32'd1000;
      end
    end
    s_last = 1'b0;
    if (!keep_valid) s_valid = 1'b0;
  endtask

  task automatic wait_idle();
    s_valid = 1'b0; s_last = 1'b0;
    repeat (8) @(negedge aclk);
    @(posedge aclk); #1;
  endtask

  task automatic check_frame(input string tag, input int wbase, input logic [31:0] sec,
                             input logic [31:0] nsec, input logic [23:0] doff);
    chk({tag, "_sec"}, mem[wbase], sec);
    chk({tag, "_nsec"}, mem[wbase + 1], nsec);
    for (int c = 0; c < NCH; c++)
      chk($sformatf("%s_slot%0d", tag, c), mem[wbase + 2 + c], {8'h80, doff + 24'(c)});
  endtask

  task automatic do_reset();
    areset = 1'b1; s_valid = 1'b0; s_last = 1'b0; err_clr = 1'b0;
    repeat (3) @(posedge aclk); #1;
    areset = 1'b0;
    @(posedge aclk); #1;
  endtask

  initial begin
    err_vec_t ev [10];
    int       irq0;
    ev[0] = '{1'b1, 6'd5,  1'b0, 1'b0, 1'b0};
    ev[1] = '{1'b1, 6'd60, 1'b0, 1'b0, 1'b1};
    ev[2] = '{1'b1, 6'd6,  1'b0, 1'b0, 1'b1};
    ev[3] = '{1'b0, 6'd0,  1'b1, 1'b0, 1'b0};
    ev[4] = '{1'b1, 6'd60, 1'b1, 1'b0, 1'b0};
    ev[5] = '{1'b1, 6'd63, 1'b0, 1'b0, 1'b1};
    ev[6] = '{1'b1, 6'd54, 1'b1, 1'b0, 1'b0};
    ev[7] = '{1'b1, 6'd54, 1'b0, 1'b0, 1'b1};
    ev[8] = '{1'b1, 6'd53, 1'b0, 1'b0, 1'b1};
    ev[9] = '{1'b1, 6'd60, 1'b0, 1'b1, 1'b1};

    areset = 1'b1; enable = 1'b1; s_valid = 1'b0; s_last = 1'b0; err_clr = 1'b0;
    s_ch = '0; s_data = '0; s_status = '0; rtc_sec = '0; rtc_nsec = '0;
    repeat (3) @(posedge aclk); #1;
    chk("rst_s_ready", 32'(s_ready), 0);
    chk("rst_bram_en", 32'(bram_en), 0);
    chk("rst_bram_addr", 32'(bram_addr), 0);
    chk("rst_bram_wrdata", bram_wrdata, 0);
    chk("rst_irq", 32'(irq), 0);
    chk("rst_done_bank", 32'(done_bank), 0);
    chk("rst_frame_cnt", frame_cnt, 0);
    chk("rst_err_ch", 32'(err_ch), 0);
    chk("bram_rst_follow", 32'(bram_rst), 1);
    areset = 1'b0;
    @(posedge aclk); #1;

    send_frame(32'd5, 32'd100, 24'h0, 1'b0);
    wait_idle();
    check_frame("f1", 0, 32'd5, 32'd100, 24'h0);
    chk("f1_irq_cnt", 32'(irq_cnt), 1);
    chk("f1_done_bank", 32'(done_bank), 0);
    chk("f1_frame_cnt", frame_cnt, 1);

    send_frame(32'd7, 32'd300, 24'h100, 1'b0);
    wait_idle();
    check_frame("f2", 512, 32'd7, 32'd300, 24'h100);
    chk("f2_done_bank", 32'(done_bank), 1);
    chk("f2_frame_cnt", frame_cnt, 2);

    send_frame(32'd8, 32'd400, 24'h200, 1'b0);
    wait_idle();
    check_frame("f3", 0, 32'd8, 32'd400, 24'h200);
    chk("f3_done_bank", 32'(done_bank), 0);
    chk("f3_frame_cnt", frame_cnt, 3);
    chk("f3_irq_cnt", 32'(irq_cnt), 3);

    // err_ch table; the frame lands in bank 1 and closes on an out-of-range last sample
    rtc_sec = 32'd42; rtc_nsec = 32'd4200;
    for (int i = 0; i < 10; i++) begin
      s_valid = ev[i].valid; s_ch = ev[i].ch; s_last = ev[i].last; err_clr = ev[i].clr;
      s_data = 24'h00AB00 | 24'(i); s_status = 8'h11;
      @(posedge aclk); #1;
      s_valid = 1'b0; s_last = 1'b0; err_clr = 1'b0;
      chk($sformatf("err_vec%0d", i), 32'(err_ch), 32'(ev[i].exp_err));
    end
    wait_idle();
    chk("err_frame_cnt", frame_cnt, 4);
    chk("err_done_bank", 32'(done_bank), 1);
    chk("err_slot5", mem[512 + 2 + 5], 32'h1100AB00);
    chk("err_slot53", mem[512 + 2 + 53], 32'h1100AB08);
    chk("err_sec", mem[512], 32'd42);
    chk("err_sticky", 32'(err_ch), 1);

    // abort by enable, then a full frame after reset
    do_reset();
    irq0 = irq_cnt;
    rtc_sec = 32'd1; rtc_nsec = 32'd11;
    for (int c = 0; c < 10; c++) send(6'(c), 24'h0AA000 + 24'(c), 8'h80, 1'b0);
    enable = 1'b0;
    send(6'd20, 24'h0DEAD0, 8'h80, 1'b0);
    send(6'd21, 24'h0DEAD1, 8'h80, 1'b1);
    s_valid = 1'b0; s_last = 1'b0;
    repeat (3) @(posedge aclk); #1;
    enable = 1'b1;
    send_frame(32'd9, 32'd900, 24'h300, 1'b0);
    wait_idle();
    chk("en_irq_cnt", 32'(irq_cnt - irq0), 1);
    chk("en_frame_cnt", frame_cnt, 1);
    chk("en_done_bank", 32'(done_bank), 0);
    check_frame("en", 0, 32'd9, 32'd900, 24'h300);

    // s_valid held high across two back-to-back frames
    irq0 = irq_cnt;
    send_frame(32'd10, 32'd1000, 24'h400, 1'b1);
    send_frame(32'd11, 32'd1100, 24'h500, 1'b0);
    wait_idle();
    chk("bb_irq_cnt", 32'(irq_cnt - irq0), 2);
    check_frame("bb1", 512, 32'd10, 32'd1000, 24'h400);
    check_frame("bb2", 0, 32'd11, 32'd1100, 24'h500);
    chk("bb_frame_cnt", frame_cnt, 3);

    // reset while in HDR_SEC
    irq0 = irq_cnt;
    rtc_sec = 32'd77; rtc_nsec = 32'd777;
    for (int c = 0; c < NCH; c++) send(6'(c), 24'h600 + 24'(c), 8'h80, c == NCH - 1);
    areset = 1'b1; s_valid = 1'b0; s_last = 1'b0;
    @(posedge aclk); #1;
    chk("hr_s_ready", 32'(s_ready), 0);
    chk("hr_bram_en", 32'(bram_en), 0);
    chk("hr_bram_we", 32'(bram_we), 0);
    chk("hr_bram_addr", 32'(bram_addr), 0);
    chk("hr_bram_wrdata", bram_wrdata, 0);
    chk("hr_irq", 32'(irq), 0);
    chk("hr_done_bank", 32'(done_bank), 0);
    chk("hr_frame_cnt", frame_cnt, 0);
    repeat (3) @(posedge aclk); #1;
    areset = 1'b0;
    repeat (6) @(posedge aclk); #1;
    chk("hr_no_irq", 32'(irq_cnt - irq0), 0);
    chk("hr_frame_cnt_after", frame_cnt, 0);
    chk("hr_sec_untouched", mem[512], 32'd10);

    // single-sample frame lands in bank 0 after the reset
    rtc_sec = 32'd123; rtc_nsec = 32'd456;
    send(6'd3, 24'h00BEEF, 8'h80, 1'b1);
    wait_idle();
    chk("ss_sec", mem[0], 32'd123);
    chk("ss_nsec", mem[1], 32'd456);
    chk("ss_slot3", mem[5], 32'h8000BEEF);
    chk("ss_frame_cnt", frame_cnt, 1);
    chk("ss_done_bank", 32'(done_bank), 0);

    chk("queue_empty", 32'(exp_q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

endmodule
